// File: rtl/tsu_axis_rx_if.sv
// MAC RX AXI-Stream byte bus as seen by the timestamp receiver.
// The receiver only observes the bus, so every signal is an input on the slave side.
interface tsu_axis_rx_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;
  logic       tuser;

  modport master (output tvalid, tready, tdata, tlast, tuser);
  modport slave  (input  tvalid, tready, tdata, tlast, tuser);
endinterface

// File: rtl/tsu_axis_rx.sv
// RX timestamp unit: captures RTC on first beat and reports one-way latency of critical frames.
// Optional statistics outputs are enabled by defining TSU_RX_STATS_EN.
module tsu_axis_rx #(
  parameter logic [15:0] CRIT_ETHERTYPE = 16'h88B5,
  parameter int          TS_OFFSET      = 20
) (
  input  logic                 mac_axis_aclk,
  input  logic                 rst,
  tsu_axis_rx_if.slave         mac_axis,
  input  logic [63:0]          rtc_timer_in,
  output logic                 meas_valid,
  output logic [63:0]          meas_latency,
  output logic                 meas_neg,
  output logic [63:0]          meas_rx_ts,
  output logic [63:0]          meas_tx_ts,
  output logic                 meas_err,
  output logic [1:0]           meas_err_code
`ifdef TSU_RX_STATS_EN
  ,
  output logic [31:0]          stat_crit_cnt,
  output logic [31:0]          stat_err_cnt,
  output logic [63:0]          stat_max_latency
`endif
);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  localparam logic [5:0] TS_FIRST = 6'(TS_OFFSET);
  localparam logic [5:0] TS_LAST  = 6'(TS_OFFSET + 7);
  localparam logic [5:0] CNT_MAX  = 6'd63;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg;
  logic [15:0] ethertype_reg;
  logic [63:0] rx_ts_reg;
  logic [63:0] tx_ts_reg;

  logic        meas_valid_reg, meas_valid_next;
  logic        meas_err_reg, meas_err_next;
  logic [1:0]  meas_err_code_reg, meas_err_code_next;
  logic [63:0] meas_latency_reg, meas_latency_next;
  logic        meas_neg_reg, meas_neg_next;
  logic [63:0] meas_rx_ts_reg;
  logic [63:0] meas_tx_ts_reg;

  logic        beat;
  logic        eval;
  logic        crit;
  logic        is_short;
  logic [5:0]  idx;
  logic [15:0] eth_cur;
  logic [63:0] tx_cur;

  assign beat = mac_axis.tvalid & mac_axis.tready;
  assign idx  = (state_reg == RECV) ? cnt_reg : 6'd0;
  assign eval = beat & (state_reg == RECV) & mac_axis.tlast;

  // Field views including the current beat, so a frame ending on byte 13
  // or on the timestamp tail byte is evaluated with that byte in place.
  always_comb begin
    eth_cur = ethertype_reg;
    if (idx == 6'd12) eth_cur[15:8] = mac_axis.tdata;
    if (idx == 6'd13) eth_cur[7:0]  = mac_axis.tdata;
  end

  assign tx_cur   = (idx >= TS_FIRST && idx <= TS_LAST) ? {tx_ts_reg[55:0], mac_axis.tdata}
                                                        : tx_ts_reg;
  assign crit     = (eth_cur == CRIT_ETHERTYPE);
  assign is_short = (idx < TS_LAST);

  // State register
  always_ff @(posedge mac_axis_aclk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (beat && !mac_axis.tlast) state_next = RECV;
      RECV:    if (beat && mac_axis.tlast)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: frame verdict and measurement values for the tlast beat
  always_comb begin
    meas_valid_next    = eval & crit & ~is_short & ~mac_axis.tuser;
    meas_err_next      = eval & crit & (is_short | mac_axis.tuser);
    meas_err_code_next = {mac_axis.tuser, is_short};
    meas_latency_next  = rx_ts_reg - tx_cur;
    meas_neg_next      = (tx_cur > rx_ts_reg);
  end

  // Frame parsing registers
  always_ff @(posedge mac_axis_aclk or posedge rst) begin
    if (rst) begin
      cnt_reg       <= 6'd0;
      ethertype_reg <= 16'd0;
      rx_ts_reg     <= 64'd0;
      tx_ts_reg     <= 64'd0;
    end else if (beat) begin
      if (state_reg == IDLE) begin
        cnt_reg       <= mac_axis.tlast ? 6'd0 : 6'd1;
        ethertype_reg <= 16'd0;
        tx_ts_reg     <= 64'd0;
        rx_ts_reg     <= rtc_timer_in;
      end else begin
        ethertype_reg <= eth_cur;
        tx_ts_reg     <= tx_cur;
        if (mac_axis.tlast)        cnt_reg <= 6'd0;
        else if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 6'd1;
      end
    end
  end

  // Measurement outputs; rx_ts is copied so a back-to-back frame cannot disturb it
  always_ff @(posedge mac_axis_aclk or posedge rst) begin
    if (rst) begin
      meas_valid_reg    <= 1'b0;
      meas_err_reg      <= 1'b0;
      meas_err_code_reg <= 2'd0;
      meas_latency_reg  <= 64'd0;
      meas_neg_reg      <= 1'b0;
      meas_rx_ts_reg    <= 64'd0;
      meas_tx_ts_reg    <= 64'd0;
    end else begin
      meas_valid_reg <= meas_valid_next;
      meas_err_reg   <= meas_err_next;
      if (meas_err_next) meas_err_code_reg <= meas_err_code_next;
      if (meas_valid_next) begin
        meas_latency_reg <= meas_latency_next;
        meas_neg_reg     <= meas_neg_next;
        meas_rx_ts_reg   <= rx_ts_reg;
        meas_tx_ts_reg   <= tx_cur;
      end
    end
  end

  assign meas_valid    = meas_valid_reg;
  assign meas_err      = meas_err_reg;
  assign meas_err_code = meas_err_code_reg;
  assign meas_latency  = meas_latency_reg;
  assign meas_neg      = meas_neg_reg;
  assign meas_rx_ts    = meas_rx_ts_reg;
  assign meas_tx_ts    = meas_tx_ts_reg;

`ifdef TSU_RX_STATS_EN
  logic [1:0]  stat_inc;
  logic [31:0] stat_cnt_reg [2];
  logic [63:0] stat_max_reg;

  assign stat_inc[0] = eval & crit;
  assign stat_inc[1] = meas_err_next;

  // Saturating counters: [0] critical frames, [1] error pulses
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_stat_cnt
      always_ff @(posedge mac_axis_aclk or posedge rst) begin
        if (rst)
          stat_cnt_reg[gi] <= 32'd0;
        else if (stat_inc[gi] && stat_cnt_reg[gi] != 32'hFFFF_FFFF)
          stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 32'd1;
      end
    end
  endgenerate

  always_ff @(posedge mac_axis_aclk or posedge rst) begin
    if (rst)
      stat_max_reg <= 64'd0;
    else if (meas_valid_reg && !meas_neg_reg && meas_latency_reg > stat_max_reg)
      stat_max_reg <= meas_latency_reg;
  end

  assign stat_crit_cnt    = stat_cnt_reg[0];
  assign stat_err_cnt     = stat_cnt_reg[1];
  assign stat_max_latency = stat_max_reg;
`endif

endmodule

// File: tb/tb_tsu_axis_rx.sv
// Scoreboard bench for tsu_axis_rx: stimulus pushes expected results, a monitor pops on each pulse.
module tb_tsu_axis_rx;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [63:0] lat;
    logic        neg;
    logic [63:0] rx;
    logic [63:0] tx;
  } exp_t;

  logic        mac_axis_aclk;
  logic        rst;
  logic [63:0] rtc_timer_in;
  logic        meas_valid;
  logic [63:0] meas_latency;
  logic        meas_neg;
  logic [63:0] meas_rx_ts;
  logic [63:0] meas_tx_ts;
  logic        meas_err;
  logic [1:0]  meas_err_code;
`ifdef TSU_RX_STATS_EN
  logic [31:0] stat_crit_cnt;
  logic [31:0] stat_err_cnt;
  logic [63:0] stat_max_latency;
`endif

  tsu_axis_rx_if mac_axis ();

  tsu_axis_rx dut (
    .mac_axis_aclk (mac_axis_aclk),
    .rst           (rst),
    .mac_axis      (mac_axis),
    .rtc_timer_in  (rtc_timer_in),
    .meas_valid    (meas_valid),
    .meas_latency  (meas_latency),
    .meas_neg      (meas_neg),
    .meas_rx_ts    (meas_rx_ts),
    .meas_tx_ts    (meas_tx_ts),
    .meas_err      (meas_err),
    .meas_err_code (meas_err_code)
`ifdef TSU_RX_STATS_EN
    ,
    .stat_crit_cnt    (stat_crit_cnt),
    .stat_err_cnt     (stat_err_cnt),
    .stat_max_latency (stat_max_latency)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [7:0] frame_buf [64];

  initial mac_axis_aclk = 1'b0;
  always #5 mac_axis_aclk = ~mac_axis_aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge mac_axis_aclk);
    #1;
    rtc_timer_in = rtc_timer_in + 64'd1;
  endtask

  task automatic build(input logic [15:0] eth, input logic [63:0] tx);
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'(i);
    frame_buf[12] = eth[15:8];
    frame_buf[13] = eth[7:0];
    for (int k = 0; k < 8; k++) frame_buf[20 + k] = tx[63 - 8*k -: 8];
  endtask

  task automatic push_ok(input logic [63:0] lat, input logic neg, input logic [63:0] rx,
                         input logic [63:0] tx);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.lat = lat; e.neg = neg; e.rx = rx; e.tx = tx;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.lat = '0; e.neg = 1'b0; e.rx = '0; e.tx = '0;
    exp_q.push_back(e);
  endtask

  // Drives frame_buf[from..to]; optional stalls before bytes 5 (tvalid low) and 22 (tready low).
  task automatic send_bytes(input int from, input int to, input bit last, input bit bad,
                            input bit stalls);
    for (int i = from; i <= to; i++) begin
      if (stalls && i == 5) begin
        mac_axis.tvalid = 1'b0; mac_axis.tready = 1'b1; cyc();
      end
      if (stalls && i == 22) begin
        mac_axis.tvalid = 1'b1; mac_axis.tready = 1'b0;
        mac_axis.tdata = 8'hEE; mac_axis.tlast = 1'b1; mac_axis.tuser = 1'b1;
        cyc();
      end
      mac_axis.tvalid = 1'b1;
      mac_axis.tready = 1'b1;
      mac_axis.tdata  = frame_buf[i];
      mac_axis.tlast  = last && (i == to);
      mac_axis.tuser  = bad && (i == to);
      cyc();
    end
    mac_axis.tvalid = 1'b0;
    mac_axis.tlast  = 1'b0;
    mac_axis.tuser  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   64'(meas_valid),    64'd0);
    chk({tag, "_err"},     64'(meas_err),      64'd0);
    chk({tag, "_code"},    64'(meas_err_code), 64'd0);
    chk({tag, "_latency"}, meas_latency,       64'd0);
    chk({tag, "_neg"},     64'(meas_neg),      64'd0);
    chk({tag, "_rx_ts"},   meas_rx_ts,         64'd0);
    chk({tag, "_tx_ts"},   meas_tx_ts,         64'd0);
`ifdef TSU_RX_STATS_EN
    chk({tag, "_stat_crit"}, 64'(stat_crit_cnt), 64'd0);
    chk({tag, "_stat_err"},  64'(stat_err_cnt),  64'd0);
    chk({tag, "_stat_max"},  stat_max_latency,   64'd0);
`endif
  endtask

  // Monitor: every pulse must match the oldest expected result
  always @(negedge mac_axis_aclk) begin
    if (!rst) begin
      if (meas_valid && meas_err) begin
        errors++;
        $display("FAIL both_pulses: got valid=1 err=1 expected at most one");
      end
      if (meas_valid || meas_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none", meas_valid, meas_err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_err) begin
            chk("mon_err_pulse", 64'(meas_err), 64'd1);
            chk("mon_err_code", 64'(meas_err_code), 64'(e.code));
          end else begin
            chk("mon_valid", 64'(meas_valid), 64'd1);
            chk("mon_latency", meas_latency, e.lat);
            chk("mon_neg", 64'(meas_neg), 64'(e.neg));
            chk("mon_rx_ts", meas_rx_ts, e.rx);
            chk("mon_tx_ts", meas_tx_ts, e.tx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rtc_timer_in = 64'd0;
    mac_axis.tvalid = 1'b0;
    mac_axis.tready = 1'b0;
    mac_axis.tdata  = 8'd0;
    mac_axis.tlast  = 1'b0;
    mac_axis.tuser  = 1'b0;
    for (int i = 0; i < 64; i++) frame_buf[i] = 8'd0;
    repeat (3) cyc();
    chk_reset_outputs("reset");
    rst = 1'b0;
    cyc();

    // Good critical 64-byte frame
    build(16'h88B5, 64'h3E8);
    rtc_timer_in = 64'h1388;
    push_ok(64'h0FA0, 1'b0, 64'h1388, 64'h3E8);
    send_bytes(0, 63, 1'b1, 1'b0, 1'b0);
    drain("good64");

    // Non-critical ethertype: no pulse, outputs hold
    build(16'h0800, 64'h3E8);
    rtc_timer_in = 64'h5000;
    send_bytes(0, 63, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("noncrit_latency_hold", meas_latency, 64'h0FA0);
    chk("noncrit_rx_hold", meas_rx_ts, 64'h1388);
    chk("noncrit_tx_hold", meas_tx_ts, 64'h3E8);

    // Error cases
    build(16'h88B5, 64'h1234);
    rtc_timer_in = 64'h6000;
    push_err(2'b01);
    send_bytes(0, 24, 1'b1, 1'b0, 1'b0);
    drain("short");
    push_err(2'b10);
    send_bytes(0, 63, 1'b1, 1'b1, 1'b0);
    drain("tuser");
    chk("err_latency_hold", meas_latency, 64'h0FA0);
    push_err(2'b11);
    send_bytes(0, 24, 1'b1, 1'b1, 1'b0);
    drain("short_tuser");

    // Negative latency
    build(16'h88B5, 64'h2000);
    rtc_timer_in = 64'h1000;
    push_ok(64'hFFFF_FFFF_FFFF_F000, 1'b1, 64'h1000, 64'h2000);
    send_bytes(0, 63, 1'b1, 1'b0, 1'b0);
    drain("negative");

    // Boundary: tail byte on tlast beat, then one byte too short
    build(16'h88B5, 64'h10);
    rtc_timer_in = 64'h50;
    push_ok(64'h40, 1'b0, 64'h50, 64'h10);
    send_bytes(0, 27, 1'b1, 1'b0, 1'b0);
    drain("exact_len");
    push_err(2'b01);
    send_bytes(0, 26, 1'b1, 1'b0, 1'b0);
    drain("one_short");

    // Back-to-back critical frames with stalls inside
    build(16'h88B5, 64'h100);
    rtc_timer_in = 64'h500;
    push_ok(64'h400, 1'b0, 64'h500, 64'h100);
    send_bytes(0, 63, 1'b1, 1'b0, 1'b1);
    build(16'h88B5, 64'h200);
    rtc_timer_in = 64'h900;
    push_ok(64'h700, 1'b0, 64'h900, 64'h200);
    send_bytes(0, 63, 1'b1, 1'b0, 1'b1);
    drain("b2b");

    // Reset in the middle of a critical frame
    build(16'h88B5, 64'h3000);
    rtc_timer_in = 64'h8000;
    send_bytes(0, 14, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    chk_reset_outputs("midreset");
    rst = 1'b0;
    send_bytes(15, 63, 1'b1, 1'b0, 1'b0);
    repeat (3) cyc();

    build(16'h88B5, 64'h7000);
    rtc_timer_in = 64'h9000;
    push_ok(64'h2000, 1'b0, 64'h9000, 64'h7000);
    send_bytes(0, 63, 1'b1, 1'b0, 1'b0);
    drain("after_reset");
    repeat (2) cyc();
`ifdef TSU_RX_STATS_EN
    chk("stat_crit_cnt", 64'(stat_crit_cnt), 64'd1);
    chk("stat_err_cnt", 64'(stat_err_cnt), 64'd0);
    chk("stat_max_latency", stat_max_latency, 64'h2000);
`endif

    repeat (5) cyc();
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
